// File: rtl/audio_dac_transmitter_if.sv
// Sample handshake between an audio source and the DAC transmitter.
// The source drives the master side; the transmitter takes the slave side.
interface audio_dac_transmitter_if;
  logic [11:0] sample_in;
  logic [1:0]  pd_mode;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_in,
    output pd_mode,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_in,
    input  pd_mode,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/audio_dac_transmitter.sv
// Serialises 12-bit samples as 16-bit SPI write frames for a DAC121S101-class DAC.
// A one-entry holding buffer lets the source hand over the next sample mid-frame.
module audio_dac_transmitter #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  basys_clock,
  input  logic                  reset,
  audio_dac_transmitter_if.slave src,
  output logic                  dac_sync,
  output logic                  dac_sclk,
  output logic                  dac_din,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          full_q, full_d;
  logic          ready_q;
  logic [15:0]   buf_q, buf_d;
  logic [15:0]   shift_q, shift_d;
  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic [3:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          sync_q, sclk_q, din_q, busy_q, done_q;
  logic          sync_d, sclk_d, din_d, busy_d, done_d;
  logic          accept, load, half_end, frame_end, gap_end;

  assign accept    = src.sample_valid && ready_q;
  assign load      = (state_q == IDLE) && full_q;
  assign half_end  = (half_q == HALF_LAST);
  assign frame_end = half_end && phase_q && (bit_q == 4'd0);
  assign gap_end   = (gap_q == GAP_LAST);

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full_q) state_d = SHIFT;
      SHIFT:   if (frame_end) state_d = GAP;
      GAP:     if (gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins are decoded from the current state and registered, so the line
  // lags the FSM by one cycle; phase_q=0 is the sclk-high half of a bit.
  always_comb begin
    sync_d = 1'b1;
    sclk_d = 1'b1;
    din_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      SHIFT: begin
        sync_d = 1'b0;
        sclk_d = ~phase_q;
        din_d  = shift_q[15];
        busy_d = 1'b1;
      end
      GAP: begin
        busy_d = 1'b1;
        done_d = (gap_q == '0);
      end
      default: ;
    endcase
  end

  // Counters sit at their start values whenever their state is inactive.
  always_comb begin
    full_d  = full_q;
    buf_d   = buf_q;
    shift_d = shift_q;
    half_d  = '0;
    phase_d = 1'b0;
    bit_d   = 4'd15;
    gap_d   = '0;
    if (accept) begin
      full_d = 1'b1;
      buf_d  = {2'b00, src.pd_mode, src.sample_in};
    end
    if (load) begin
      full_d  = 1'b0;
      shift_d = buf_q;
    end
    if (state_q == SHIFT) begin
      half_d  = half_end ? '0 : half_q + HW'(1);
      phase_d = half_end ? ~phase_q : phase_q;
      bit_d   = bit_q;
      if (half_end && phase_q) begin
        bit_d   = bit_q - 4'd1;
        shift_d = {shift_q[14:0], 1'b0};
      end
    end
    if (state_q == GAP) begin
      gap_d = gap_end ? '0 : gap_q + GW'(1);
    end
  end

  always_ff @(posedge basys_clock) begin
    if (reset) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      buf_q   <= '0;
      shift_q <= '0;
      half_q  <= '0;
      phase_q <= 1'b0;
      bit_q   <= 4'd15;
      gap_q   <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      full_q  <= full_d;
      ready_q <= ~full_d;
      buf_q   <= buf_d;
      shift_q <= shift_d;
      half_q  <= half_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign src.sample_ready = ready_q;
  assign dac_sync         = sync_q;
  assign dac_sclk         = sclk_q;
  assign dac_din          = din_q;
  assign busy             = busy_q;
  assign frame_done       = done_q;
endmodule

// File: tb/tb_audio_dac_transmitter.sv
// Randomised bench for audio_dac_transmitter: a line monitor decodes SPI frames
// from the pins and each scenario compares them against words built from the inputs.
module tb_audio_dac_transmitter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-parameter instance
  logic rst = 1'b1;
  logic sync, sclk, din, busy, fdone;
  audio_dac_transmitter_if a_if ();
  audio_dac_transmitter #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
    .basys_clock(clk), .reset(rst), .src(a_if.slave),
    .dac_sync(sync), .dac_sclk(sclk), .dac_din(din), .busy(busy), .frame_done(fdone)
  );

  // Fastest-parameter instance
  logic f_rst = 1'b1;
  logic f_sync, f_sclk, f_din, f_busy, f_fdone;
  audio_dac_transmitter_if f_if ();
  audio_dac_transmitter #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
    .basys_clock(clk), .reset(f_rst), .src(f_if.slave),
    .dac_sync(f_sync), .dac_sclk(f_sclk), .dac_din(f_din), .busy(f_busy), .frame_done(f_fdone)
  );

  // Line monitor: bits are taken at sclk falling edges while sync is low
  logic prev_sync = 1'b1, prev_sclk = 1'b1, prev_busy = 1'b0;
  int low_len = 0, nfall = 0;
  logic [15:0] shreg = '0;
  logic [15:0] word_q[$];
  int nf_q[$], len_q[$], rise_q[$], fall_q[$], fd_q[$], bfall_q[$], ff_q[$];

  always @(negedge clk) begin
    prev_sync <= sync;
    prev_sclk <= sclk;
    prev_busy <= busy;
    if (!sync) begin
      if (prev_sync) begin
        low_len <= 1;
        nfall   <= 0;
        shreg   <= '0;
        fall_q.push_back(cyc);
      end else begin
        low_len <= low_len + 1;
        if (prev_sclk && !sclk) begin
          shreg <= {shreg[14:0], din};
          nfall <= nfall + 1;
          if (nfall == 0) ff_q.push_back(cyc);
        end
      end
    end else if (!prev_sync) begin
      word_q.push_back(shreg);
      nf_q.push_back(nfall);
      len_q.push_back(low_len);
      rise_q.push_back(cyc);
    end
    if (fdone) fd_q.push_back(cyc);
    if (prev_busy && !busy) bfall_q.push_back(cyc);
  end

  logic fp_sync = 1'b1, fp_sclk = 1'b1;
  int f_len = 0, f_nf = 0, f_bad = 0;
  logic [15:0] f_sh = '0;
  logic [15:0] f_word_q[$];
  int f_len_q[$], f_nf_q[$], f_bad_q[$];

  always @(negedge clk) begin
    fp_sync <= f_sync;
    fp_sclk <= f_sclk;
    if (!f_sync) begin
      if (fp_sync) begin
        f_len <= 1;
        f_nf  <= 0;
        f_sh  <= '0;
        f_bad <= 0;
      end else begin
        f_len <= f_len + 1;
        if (f_sclk == fp_sclk) f_bad <= f_bad + 1;
        if (fp_sclk && !f_sclk) begin
          f_sh <= {f_sh[14:0], f_din};
          f_nf <= f_nf + 1;
        end
      end
    end else if (!fp_sync) begin
      f_word_q.push_back(f_sh);
      f_len_q.push_back(f_len);
      f_nf_q.push_back(f_nf);
      f_bad_q.push_back(f_bad);
    end
  end

  task automatic clear_mon();
    word_q.delete(); nf_q.delete(); len_q.delete(); rise_q.delete();
    fall_q.delete(); fd_q.delete(); bfall_q.delete(); ff_q.delete();
  endtask

  // Present a sample and return the cycle label of the accepting edge
  task automatic send(input logic [11:0] s, input logic [1:0] p, output int hs);
    int n;
    @(negedge clk);
    a_if.sample_in    = s;
    a_if.pd_mode      = p;
    a_if.sample_valid = 1'b1;
    n = 0;
    while (a_if.sample_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      $display("FAIL send_timeout sample_ready=%b required 1", a_if.sample_ready);
      $fatal(1, "sample_ready never rose");
    end
    hs = cyc + 1;
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    a_if.sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (word_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sync, sclk, din, busy, fdone, a_if.sample_ready} !== 6'b110000)
      $display("FAIL reset_outputs got %b required 110000",
               {sync, sclk, din, busy, fdone, a_if.sample_ready});
    if ({sync, sclk, din, busy, fdone, a_if.sample_ready} !== 6'b110000) errors++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b required 1", a_if.sample_ready);
    end
  endtask

  task automatic test_single();
    int hs;
    clear_mon();
    send(12'hA5C, 2'b00, hs);
    drop();
    wait_frames(1, 400);
    repeat (30) @(posedge clk);
    checks++;
    if (word_q.size() != 1) begin errors++; $display("FAIL single_count got %0d required 1", word_q.size()); end
    checks++;
    if (word_q[0] !== 16'h0A5C) begin errors++; $display("FAIL single_word got %h required 0a5c", word_q[0]); end
    checks++;
    if (fall_q[0] != hs + 2) begin errors++; $display("FAIL single_sync_latency got %0d required %0d", fall_q[0], hs + 2); end
    checks++;
    if (len_q[0] != 128) begin errors++; $display("FAIL single_sync_len got %0d required 128", len_q[0]); end
    checks++;
    if (nf_q[0] != 16) begin errors++; $display("FAIL single_falls got %0d required 16", nf_q[0]); end
    checks++;
    if (ff_q[0] != fall_q[0] + 4) begin errors++; $display("FAIL first_fall got %0d required %0d", ff_q[0], fall_q[0] + 4); end
    checks++;
    if (fd_q.size() != 1 || fd_q[0] != rise_q[0]) begin
      errors++;
      $display("FAIL frame_done got count=%0d at %0d required 1 at %0d", fd_q.size(), fd_q[0], rise_q[0]);
    end
    checks++;
    if (bfall_q.size() != 1 || bfall_q[0] != fd_q[0] + 8) begin
      errors++;
      $display("FAIL busy_fall got %0d required %0d", bfall_q[0], fd_q[0] + 8);
    end
  endtask

  task automatic test_back_to_back();
    int hs;
    logic [15:0] exp_w[3];
    exp_w[0] = 16'h0000; exp_w[1] = 16'h0FFF; exp_w[2] = 16'h0800;
    clear_mon();
    send(12'h000, 2'b00, hs);
    send(12'hFFF, 2'b00, hs);
    @(negedge clk);
    checks++;
    if (a_if.sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b required 0", a_if.sample_ready); end
    send(12'h800, 2'b00, hs);
    drop();
    wait_frames(3, 800);
    repeat (300) @(posedge clk);
    checks++;
    if (word_q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d required 3", word_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (word_q[i] !== exp_w[i]) begin errors++; $display("FAIL b2b_word%0d got %h required %h", i, word_q[i], exp_w[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (rise_q[i] - rise_q[i-1] != 137) begin
        errors++;
        $display("FAIL b2b_spacing%0d got %0d required 137", i, rise_q[i] - rise_q[i-1]);
      end
    end
  endtask

  task automatic test_pd_mode();
    int hs;
    clear_mon();
    send(12'h123, 2'b11, hs);
    drop();
    wait_frames(1, 400);
    checks++;
    if (word_q.size() != 1 || word_q[0] !== 16'h3123) begin
      errors++;
      $display("FAIL pd_word got %h (count %0d) required 3123", word_q[0], word_q.size());
    end
  endtask

  task automatic test_random();
    int hs;
    logic [11:0] s;
    logic [1:0] p;
    logic [15:0] exp_q[$];
    clear_mon();
    for (int i = 0; i < 12; i++) begin
      s = 12'($urandom_range(0, 4095));
      p = 2'($urandom_range(0, 3));
      exp_q.push_back({2'b00, p, s});
      send(s, p, hs);
      if ($urandom_range(0, 1) == 1) begin
        drop();
        repeat ($urandom_range(0, 300)) @(posedge clk);
      end
    end
    drop();
    wait_frames(12, 12 * 450);
    repeat (200) @(posedge clk);
    checks++;
    if (word_q.size() != 12) begin errors++; $display("FAIL rand_count got %0d required 12", word_q.size()); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (word_q[i] !== exp_q[i] || len_q[i] != 128 || nf_q[i] != 16) begin
        errors++;
        $display("FAIL rand_frame%0d got %h len=%0d falls=%0d required %h len=128 falls=16",
                 i, word_q[i], len_q[i], nf_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gating();
    int hs;
    clear_mon();
    send(12'h222, 2'b00, hs);
    send(12'h333, 2'b00, hs);
    @(negedge clk);
    checks++;
    if (a_if.sample_ready !== 1'b0) begin errors++; $display("FAIL gate_ready got %b required 0", a_if.sample_ready); end
    a_if.sample_in = 12'h111;
    @(negedge clk);
    a_if.sample_valid = 1'b0;
    wait_frames(2, 800);
    repeat (400) @(posedge clk);
    checks++;
    if (word_q.size() != 2 || word_q[0] !== 16'h0222 || word_q[1] !== 16'h0333) begin
      errors++;
      $display("FAIL gate_frames got count=%0d %h %h required 2 0222 0333", word_q.size(), word_q[0], word_q[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int hs, k;
    clear_mon();
    send(12'h789, 2'b00, hs);
    send(12'hABC, 2'b00, hs);
    drop();
    k = 0;
    while (fall_q.size() == 0 && k < 400) begin @(posedge clk); k++; end
    repeat (59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({sync, sclk, din, busy, fdone, a_if.sample_ready} !== 6'b110000) begin
      errors++;
      $display("FAIL abort_outputs got %b required 110000", {sync, sclk, din, busy, fdone, a_if.sample_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_if.sample_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b required 1", a_if.sample_ready); end
    @(posedge clk);
    checks++;
    if (word_q.size() != 1 || nf_q[0] >= 16) begin
      errors++;
      $display("FAIL abort_falls got count=%0d falls=%0d required 1 frame under 16", word_q.size(), nf_q[0]);
    end
    clear_mon();
    send(12'h456, 2'b00, hs);
    drop();
    wait_frames(1, 400);
    repeat (400) @(posedge clk);
    checks++;
    if (word_q.size() != 1 || word_q[0] !== 16'h0456 || nf_q[0] != 16) begin
      errors++;
      $display("FAIL abort_recover got count=%0d %h falls=%0d required 1 0456 16", word_q.size(), word_q[0], nf_q[0]);
    end
  endtask

  task automatic test_fast();
    logic [11:0] s[2];
    logic [15:0] exp_w[2];
    int n;
    s[0] = 12'hFFF; exp_w[0] = 16'h0FFF;
    s[1] = 12'h5A3; exp_w[1] = 16'h15A3;
    f_rst = 1'b1;
    repeat (2) @(negedge clk);
    f_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      f_if.sample_in    = s[i];
      f_if.pd_mode      = (i == 1) ? 2'b01 : 2'b00;
      f_if.sample_valid = 1'b1;
      n = 0;
      while (f_if.sample_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      @(negedge clk);
      f_if.sample_valid = 1'b0;
    end
    repeat (100) @(posedge clk);
    checks++;
    if (f_word_q.size() != 2) begin errors++; $display("FAIL fast_count got %0d required 2", f_word_q.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (f_word_q[i] !== exp_w[i] || f_len_q[i] != 32 || f_nf_q[i] != 16 || f_bad_q[i] != 0) begin
        errors++;
        $display("FAIL fast_frame%0d got %h len=%0d falls=%0d stalls=%0d required %h len=32 falls=16 stalls=0",
                 i, f_word_q[i], f_len_q[i], f_nf_q[i], f_bad_q[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.sample_in = '0; a_if.pd_mode = '0; a_if.sample_valid = 1'b0;
    f_if.sample_in = '0; f_if.pd_mode = '0; f_if.sample_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_pd_mode();
    test_gating();
    test_reset_mid_frame();
    test_random();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
